// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling, start-bit validation and a
// first-word-fall-through byte FIFO drained one byte per pop.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DIV        = CLK_FREQ / (BAUD * 16),
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          iCLK,
  input  logic                          Reset,
  input  logic                          iUART_RXD,
  input  logic                          iRxPop,
  input  logic                          iClearErr,
  output logic [7:0]                    oRxData,
  output logic                          oRxValid,
  output logic [$clog2(FIFO_DEPTH):0]   oCount,
  output logic                          oFramingErr,
  output logic                          oOverrun,
  output logic                          oBusy,
  output logic [2:0]                    oState
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    STOP     = 3'd3,
    WAITHIGH = 3'd4
  } state_t;

  state_t        state;
  logic          rxMeta;
  logic          rxs;
  logic          rxPrev;
  logic [TW-1:0] tickCnt;
  logic          tick;
  logic [3:0]    sc;
  logic [2:0]    bi;
  logic [7:0]    shiftReg;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0]   count;

  logic startEdge;
  logic stopSample;
  logic pushReq;
  logic frameErr;
  logic full;
  logic popOk;
  logic pushOk;
  logic overrunEv;

  assign tick       = (tickCnt == TW'(DIV - 1));
  assign startEdge  = (state == IDLE) && rxPrev && !rxs;
  assign stopSample = (state == STOP) && tick && (sc == 4'd15);
  assign pushReq    = stopSample && rxs;
  assign frameErr   = stopSample && !rxs;
  assign full       = (count == (AW+1)'(FIFO_DEPTH));
  // Handshake: oRxValid means oRxData holds the head byte; a pop is taken on
  // any edge where iRxPop=1 and oRxValid=1, and is ignored otherwise.
  assign popOk      = iRxPop && (count != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign pushOk     = pushReq && (!full || popOk);
  assign overrunEv  = pushReq && full && !popOk;

  always_ff @(posedge iCLK) begin
    if (!Reset) begin
      rxMeta <= 1'b1;
      rxs    <= 1'b1;
      rxPrev <= 1'b1;
    end else begin
      rxMeta <= iUART_RXD;
      rxs    <= rxMeta;
      rxPrev <= rxs;
    end
  end

  // Restarting the divider on the start edge centres later samples in each bit.
  always_ff @(posedge iCLK) begin
    if (!Reset || startEdge) tickCnt <= '0;
    else if (tick)           tickCnt <= '0;
    else                     tickCnt <= tickCnt + TW'(1);
  end

  always_ff @(posedge iCLK) begin
    if (!Reset) begin
      state    <= IDLE;
      sc       <= 4'd0;
      bi       <= 3'd0;
      shiftReg <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (startEdge) begin
            state <= START;
            sc    <= 4'd0;
          end
        end
        START: begin
          if (tick) begin
            if (sc == 4'd7) begin
              sc <= 4'd0;
              bi <= 3'd0;
              state <= rxs ? IDLE : DATA;
            end else begin
              sc <= sc + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (sc == 4'd15) begin
              sc       <= 4'd0;
              shiftReg <= {rxs, shiftReg[7:1]};
              if (bi == 3'd7) state <= STOP;
              else            bi    <= bi + 3'd1;
            end else begin
              sc <= sc + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (sc == 4'd15) begin
              sc    <= 4'd0;
              state <= rxs ? IDLE : WAITHIGH;
            end else begin
              sc <= sc + 4'd1;
            end
          end
        end
        WAITHIGH: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (!Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'd0;
    end else begin
      if (pushOk) begin
        mem[wrPtr] <= shiftReg;
        wrPtr      <= wrPtr + AW'(1);
      end
      if (popOk) rdPtr <= rdPtr + AW'(1);
      case ({pushOk, popOk})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (!Reset) begin
      oFramingErr <= 1'b0;
      oOverrun    <= 1'b0;
    end else begin
      if (frameErr)       oFramingErr <= 1'b1;
      else if (iClearErr) oFramingErr <= 1'b0;
      if (overrunEv)      oOverrun    <= 1'b1;
      else if (iClearErr) oOverrun    <= 1'b0;
    end
  end

  assign oRxData  = mem[rdPtr];
  assign oRxValid = (count != '0);
  assign oCount   = count;
  assign oBusy    = (state != IDLE);
  assign oState   = state;

endmodule
